// File: rtl/load_store_unit.sv
// Load/store unit: data-memory initiator for the execute stage.
// Takes one request at a time, converts the byte address to a word index,
// handles byte/half/word accesses (sub-word stores via read-modify-write)
// and returns exactly one response pulse per accepted request.
module load_store_unit #(
  parameter int N         = 32,
  parameter int MEM_WORDS = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_we,
  input  logic [1:0]   req_size,
  input  logic         req_unsigned,
  input  logic [N-1:0] req_addr,
  input  logic [N-1:0] req_wdata,
  output logic         resp_valid,
  output logic         resp_err,
  output logic [N-1:0] resp_rdata,
  output logic         mem_rw,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  input  logic [N-1:0] mem_rdata
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD   = 3'd1;
  localparam logic [2:0] RMW_RD = 3'd2;
  localparam logic [2:0] WRITE  = 3'd3;
  localparam logic [2:0] RESP   = 3'd4;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  // First word index that lies beyond the end of the data memory.
  localparam logic [N-3:0] MAX_IDX = (N-2)'(MEM_WORDS);

  logic [2:0]   state;
  logic [1:0]   size_q;
  logic         uns_q;
  logic [N-1:0] addr_q;
  logic [N-1:0] wdata_q;
  logic [N-1:0] merge_q;

  logic         req_err;
  logic [4:0]   lane_shift;
  logic [15:0]  lane_bits;
  logic [N-1:0] load_ext;
  logic [N-1:0] lane_mask;
  logic [N-1:0] merged;

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  // Gating with rst_n keeps a reset that lands in WRITE from issuing a store.
  assign mem_rw     = !(rst_n && (state == WRITE));
  assign mem_addr   = {2'b00, addr_q[N-1:2]};
  assign mem_wdata  = (size_q == SZ_WORD) ? wdata_q : merged;

  // Byte and half lanes share one shifter: a legal half address has addr[0]=0.
  assign lane_shift = {addr_q[1:0], 3'b000};
  assign lane_bits  = 16'(mem_rdata >> lane_shift);

  // Classify the incoming request so bad ones skip memory entirely.
  always_comb begin
    req_err = 1'b0;
    if (req_size == SZ_ILL)                             req_err = 1'b1;
    if ((req_size == SZ_HALF) && req_addr[0])           req_err = 1'b1;
    if ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00)) req_err = 1'b1;
    if (req_addr[N-1:2] >= MAX_IDX)                     req_err = 1'b1;
  end

  // Extract the addressed lane from the read word and sign/zero extend it.
  always_comb begin
    load_ext = mem_rdata;
    case (size_q)
      SZ_BYTE: load_ext = uns_q ? {{(N-8){1'b0}}, lane_bits[7:0]}
                                : {{(N-8){lane_bits[7]}}, lane_bits[7:0]};
      SZ_HALF: load_ext = uns_q ? {{(N-16){1'b0}}, lane_bits}
                                : {{(N-16){lane_bits[15]}}, lane_bits};
      default: load_ext = mem_rdata;
    endcase
  end

  // Splice the store data into the addressed lane of the word read in RMW_RD.
  always_comb begin
    lane_mask = '0;
    if (size_q == SZ_HALF) lane_mask = {{(N-16){1'b0}}, 16'hFFFF} << lane_shift;
    else                   lane_mask = {{(N-8){1'b0}}, 8'hFF} << lane_shift;
    merged = (merge_q & ~lane_mask) | ((wdata_q << lane_shift) & lane_mask);
  end

  // Request sequencing FSM with the latched request and response registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      size_q     <= '0;
      uns_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      merge_q    <= '0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            if (req_err) begin
              resp_err   <= 1'b1;
              resp_rdata <= '0;
              state      <= RESP;
            end else if (!req_we) begin
              state <= LOAD;
            end else if (req_size == SZ_WORD) begin
              state <= WRITE;
            end else begin
              state <= RMW_RD;
            end
          end
        end
        LOAD: begin
          resp_rdata <= load_ext;
          resp_err   <= 1'b0;
          state      <= RESP;
        end
        RMW_RD: begin
          merge_q <= mem_rdata;
          state   <= WRITE;
        end
        WRITE: begin
          resp_rdata <= '0;
          resp_err   <= 1'b0;
          state      <= RESP;
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
